// File: rtl/fixfloat_conv_if.sv
// Request/response bundle for the fixed-point <-> IEEE-754 single converter.
// The master issues requests and consumes results; the slave is the converter.
interface fixfloat_conv_if #(
  parameter int POS_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             opcode;
  logic [31:0]      targetnumber;
  logic [POS_W-1:0] fixpointpos;
  logic             rmode;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic             ovf;
  logic             inexact;

  modport master (
    output in_valid, opcode, targetnumber, fixpointpos, rmode, out_ready,
    input  in_ready, out_valid, result, ovf, inexact
  );

  modport slave (
    input  in_valid, opcode, targetnumber, fixpointpos, rmode, out_ready,
    output in_ready, out_valid, result, ovf, inexact
  );
endinterface

// File: rtl/fixfloat_conv.sv
// Iterative signed fixed-point <-> IEEE-754 single converter; one normalising
// or denormalising shift per cycle, with truncate / round-nearest-even.
module fixfloat_conv #(
  parameter int FIX_W = 32,
  parameter int POS_W = 5
) (
  input logic            clk,
  input logic            rst,
  fixfloat_conv_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WORK, S_ROUND, S_DONE} state_t;

  localparam logic [1:0] K_NORM = 2'd0;
  localparam logic [1:0] K_ZERO = 2'd1;
  localparam logic [1:0] K_SAT  = 2'd2;
  localparam logic [1:0] K_NAN  = 2'd3;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic             rmode_q, rmode_d;
  logic             sign_q, sign_d;
  logic             left_q, left_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic [1:0]       kind_q, kind_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [31:0]      work_q, work_d;
  logic [31:0]      result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             inexact_q, inexact_d;

  logic             accept;
  logic             work_done;

  // Request decode, only meaningful on the accepting cycle
  logic [POS_W-1:0] pos_in;
  logic [FIX_W-1:0] fix_in;
  logic [FIX_W-1:0] fix_mag;
  logic [7:0]       f_exp;
  logic [22:0]      f_frac;
  int               e_in;
  int               s_in;

  always_comb begin : decode
    if (32'(bus.fixpointpos) >= 32'(FIX_W)) begin
      pos_in = POS_W'(FIX_W - 1);
    end else begin
      pos_in = bus.fixpointpos;
    end
    fix_in  = bus.targetnumber[FIX_W-1:0];
    fix_mag = fix_in[FIX_W-1] ? (~fix_in + FIX_W'(1)) : fix_in;
    f_exp   = bus.targetnumber[30:23];
    f_frac  = bus.targetnumber[22:0];
    e_in    = int'(f_exp) - 127 + int'(pos_in);
    s_in    = e_in - 23;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)        state_d = S_WORK;
      S_WORK:  if (work_done)     state_d = S_ROUND;
      S_ROUND:                    state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin : fsm_out
    bus.in_ready  = (state_q == S_IDLE) && !rst;
    bus.out_valid = (state_q == S_DONE);
  end

  assign accept      = bus.in_valid && bus.in_ready;
  assign bus.result  = result_q;
  assign bus.ovf     = ovf_q;
  assign bus.inexact = inexact_q;

  // Float->fixed counts a known shift distance down; fixed->float shifts until the MSB is set.
  assign work_done = (kind_q != K_NORM) || (op_q ? (cnt_q == 6'd0) : work_q[FIX_W-1]);

  // Fixed->float packing from the normalised magnitude
  logic [62:0] x_ext;
  logic [22:0] x_mant;
  logic        x_guard, x_sticky, x_up;
  logic [23:0] x_mant_r;
  logic [7:0]  x_exp;
  logic [31:0] x_res;
  logic        x_inexact;

  always_comb begin : x2f_round
    x_ext = '0;
    x_ext[62 -: (FIX_W-1)] = work_q[FIX_W-2:0];
    x_mant   = x_ext[62:40];
    x_guard  = x_ext[39];
    x_sticky = |x_ext[38:0];
    x_up     = rmode_q & x_guard & (x_sticky | x_mant[0]);
    x_mant_r = {1'b0, x_mant} + 24'(x_up);
    x_exp    = 8'(127 + FIX_W - 1) - 8'(cnt_q) - 8'(pos_q) + 8'(x_mant_r[23]);
    if (kind_q == K_ZERO) begin
      x_res     = 32'h0000_0000;
      x_inexact = 1'b0;
    end else begin
      x_res     = {sign_q, x_exp, x_mant_r[22:0]};
      x_inexact = x_guard | x_sticky;
    end
  end

  // Float->fixed rounding, saturation and negation
  logic                    f_up;
  logic [32:0]             f_mag;
  logic [32:0]             lim_pos, lim_neg;
  logic                    f_sat;
  logic [FIX_W-1:0]        fix_max, fix_min;
  logic signed [FIX_W-1:0] fix_val;
  logic                    f_ovf, f_inexact;
  logic [31:0]             f_res;

  always_comb begin : f2x_round
    f_up      = rmode_q & guard_q & (sticky_q | work_q[0]);
    f_mag     = {1'b0, work_q} + 33'(f_up);
    lim_neg   = 33'd1 << (FIX_W - 1);
    lim_pos   = lim_neg - 33'd1;
    f_sat     = sign_q ? (f_mag > lim_neg) : (f_mag > lim_pos);
    fix_max   = {1'b0, {(FIX_W-1){1'b1}}};
    fix_min   = {1'b1, {(FIX_W-1){1'b0}}};
    fix_val   = '0;
    f_ovf     = 1'b0;
    f_inexact = 1'b0;
    case (kind_q)
      K_NAN: begin
        f_ovf = 1'b1;
      end
      K_SAT: begin
        fix_val = sign_q ? fix_min : fix_max;
        f_ovf   = 1'b1;
      end
      K_ZERO: begin
        f_inexact = sticky_q;
      end
      default: begin
        f_inexact = guard_q | sticky_q;
        if (f_sat) begin
          fix_val = sign_q ? fix_min : fix_max;
          f_ovf   = 1'b1;
        end else if (sign_q) begin
          fix_val = -f_mag[FIX_W-1:0];
        end else begin
          fix_val = f_mag[FIX_W-1:0];
        end
      end
    endcase
    f_res = 32'(fix_val);
  end

  // Datapath next-state
  always_comb begin : datapath
    op_d      = op_q;
    rmode_d   = rmode_q;
    sign_d    = sign_q;
    left_d    = left_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    kind_d    = kind_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    inexact_d = inexact_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = bus.opcode;
          rmode_d  = bus.rmode;
          pos_d    = pos_in;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          left_d   = 1'b0;
          cnt_d    = 6'd0;
          kind_d   = K_NORM;
          if (!bus.opcode) begin
            sign_d = fix_in[FIX_W-1];
            work_d = '0;
            work_d[FIX_W-1:0] = fix_mag;
            if (fix_mag == '0) kind_d = K_ZERO;
          end else begin
            sign_d = bus.targetnumber[31];
            work_d = {8'h00, 1'b1, f_frac};
            if (f_exp == 8'hFF) begin
              kind_d = (f_frac != 23'd0) ? K_NAN : K_SAT;
            end else if (f_exp == 8'h00) begin
              kind_d   = K_ZERO;
              sticky_d = |f_frac;
            end else if (e_in >= FIX_W) begin
              kind_d = K_SAT;
            end else if (s_in >= 0) begin
              left_d = 1'b1;
              cnt_d  = 6'(s_in);
            end else begin
              // Past 26 right shifts every significand bit has already folded into sticky
              cnt_d = (s_in < -26) ? 6'd26 : 6'(-s_in);
            end
          end
        end
      end
      S_WORK: begin
        if (!work_done) begin
          if (op_q) begin
            cnt_d = cnt_q - 6'd1;
            if (left_q) begin
              work_d = work_q << 1;
            end else begin
              work_d   = work_q >> 1;
              guard_d  = work_q[0];
              sticky_d = sticky_q | guard_q;
            end
          end else begin
            work_d = work_q << 1;
            cnt_d  = cnt_q + 6'd1;
          end
        end
      end
      S_ROUND: begin
        result_d  = op_q ? f_res : x_res;
        ovf_d     = op_q ? f_ovf : 1'b0;
        inexact_d = op_q ? f_inexact : x_inexact;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 1'b0;
      rmode_q   <= 1'b0;
      sign_q    <= 1'b0;
      left_q    <= 1'b0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      kind_q    <= K_NORM;
      pos_q     <= '0;
      cnt_q     <= 6'd0;
      work_q    <= 32'd0;
      result_q  <= 32'd0;
      ovf_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      rmode_q   <= rmode_d;
      sign_q    <= sign_d;
      left_q    <= left_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      kind_q    <= kind_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      inexact_q <= inexact_d;
    end
  end

endmodule
